// File: rtl/control_commit_ctrl_pkg.sv
// Shared widths and FSM encoding for the control-instruction commit sequencer.
//   ROB_IDX_W : ROB index width
//   PREG_W    : physical register index width
//   control_commit_state_t : sequencer states
package control_commit_ctrl_pkg;

  localparam int ROB_IDX_W = 5;
  localparam int PREG_W    = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BCAST    = 2'd1,
    WAIT_ROB = 2'd2,
    REDIRECT = 2'd3
  } control_commit_state_t;

endpackage

// File: rtl/control_commit_ctrl_if.sv
// Bundle of control-queue head, CDB, ROB-head and redirect signals around the
// commit sequencer.
//   master : the sequencer (consumes queue/ROB state, drives CDB/redirect)
//   slave  : the surrounding pipeline (queue, CDB arbiter, ROB, fetch)
interface control_commit_ctrl_if
  import control_commit_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 32
);
  // control queue head
  logic                   q_empty;
  logic                   q_head_valid;
  logic                   q_head_pc_valid;
  logic                   q_head_br_en;
  logic [31:0]            q_head_pc_new;
  logic [PREG_W-1:0]      q_head_pd;
  logic [ROB_IDX_W-1:0]   q_head_rob_idx;
  logic                   q_dequeue;
  // CDB
  logic                   cdb_req;
  logic                   cdb_gnt;
  logic [PREG_W-1:0]      cdb_pd;
  logic [ROB_IDX_W-1:0]   cdb_rob_idx;
  // ROB
  logic                   rob_head_valid;
  logic [ROB_IDX_W-1:0]   rob_head_idx;
  logic                   rob_flush;
  // front-end redirect
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   flush_req;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    input  q_empty, q_head_valid, q_head_pc_valid, q_head_br_en, q_head_pc_new,
           q_head_pd, q_head_rob_idx, cdb_gnt, rob_head_valid, rob_head_idx,
           rob_flush,
    output q_dequeue, cdb_req, cdb_pd, cdb_rob_idx, redirect_valid,
           redirect_pc, flush_req, stall_cycles
  );

  modport slave (
    output q_empty, q_head_valid, q_head_pc_valid, q_head_br_en, q_head_pc_new,
           q_head_pd, q_head_rob_idx, cdb_gnt, rob_head_valid, rob_head_idx,
           rob_flush,
    input  q_dequeue, cdb_req, cdb_pd, cdb_rob_idx, redirect_valid,
           redirect_pc, flush_req, stall_cycles
  );

endinterface

// File: rtl/control_commit_ctrl.sv
// Commit sequencer for the in-order control-instruction queue.
// Waits for the queue head's target to resolve, captures it, broadcasts its
// destination on the CDB (dequeueing in the grant cycle), and for taken
// control flow waits until the instruction is at the ROB head before issuing
// a one-cycle redirect + flush request.
//   clk, rst : clock, async active-low reset
//   bus      : control_commit_ctrl_if.master (queue head, CDB, ROB, redirect,
//              stall_cycles performance counter)
module control_commit_ctrl
  import control_commit_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  control_commit_ctrl_if.master bus
);

  control_commit_state_t  state_q, state_d;
  logic [PREG_W-1:0]      pd_q, pd_d;
  logic [ROB_IDX_W-1:0]   rob_q, rob_d;
  logic                   br_q, br_d;
  logic [31:0]            pc_q, pc_d;
  logic [STALL_CNT_W-1:0] stall_q;

  logic                   dequeue, cdb_req, redirect_valid, flush_req;
  logic [PREG_W-1:0]      cdb_pd;
  logic [ROB_IDX_W-1:0]   cdb_rob_idx;
  logic [31:0]            redirect_pc;

  logic head_rdy, head_live, rob_match;
  assign head_rdy  = !bus.q_empty && bus.q_head_valid && bus.q_head_pc_valid;
  assign head_live = !bus.q_empty && bus.q_head_valid;
  assign rob_match = bus.rob_head_valid && (bus.rob_head_idx == rob_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pd_q    <= '0;
      rob_q   <= '0;
      br_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pd_q    <= pd_d;
      rob_q   <= rob_d;
      br_q    <= br_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pd_d           = pd_q;
    rob_d          = rob_q;
    br_d           = br_q;
    pc_d           = pc_q;
    dequeue        = 1'b0;
    cdb_req        = 1'b0;
    cdb_pd         = '0;
    cdb_rob_idx    = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush_req      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (head_rdy) begin
          pd_d    = bus.q_head_pd;
          rob_d   = bus.q_head_rob_idx;
          br_d    = bus.q_head_br_en;
          pc_d    = bus.q_head_pc_new;
          state_d = BCAST;
        end
      end
      BCAST: begin
        // A head that vanished under us is abandoned without requesting the
        // CDB, so nothing is broadcast for an entry we will not dequeue.
        if (!head_live) begin
          state_d = IDLE;
        end else begin
          cdb_req     = 1'b1;
          cdb_pd      = pd_q;
          cdb_rob_idx = rob_q;
          if (bus.cdb_gnt) begin
            dequeue = 1'b1;
            // Skip WAIT_ROB when the entry is already at the ROB head so a
            // taken branch redirects two cycles after its head became ready.
            if (!br_q)          state_d = IDLE;
            else if (rob_match) state_d = REDIRECT;
            else                state_d = WAIT_ROB;
          end
        end
      end
      WAIT_ROB: begin
        if (rob_match) state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = pc_q;
        flush_req      = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An older flush overrides everything, including a pending redirect.
    if (bus.rob_flush) begin
      state_d        = IDLE;
      pd_d           = '0;
      rob_d          = '0;
      br_d           = 1'b0;
      pc_d           = '0;
      dequeue        = 1'b0;
      cdb_req        = 1'b0;
      cdb_pd         = '0;
      cdb_rob_idx    = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      flush_req      = 1'b0;
    end
  end

  // Saturating CDB-stall counter; survives rob_flush, only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_q <= '0;
    else if (cdb_req && !bus.cdb_gnt && (stall_q != '1))
      stall_q <= stall_q + STALL_CNT_W'(1);
  end

  assign bus.q_dequeue      = dequeue;
  assign bus.cdb_req        = cdb_req;
  assign bus.cdb_pd         = cdb_pd;
  assign bus.cdb_rob_idx    = cdb_rob_idx;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.flush_req      = flush_req;
  assign bus.stall_cycles   = stall_q;

endmodule
